counter_ctrl: RTL

Controller that sequences the 16-bit event counter on the board. It debounces three push-buttons (step, run/pause, clear) and runs a prescaler that generates a periodic auto-increment tick. It arbitrates all increment and clear requests through a 4-state FSM. It drives the counter's increment and active-low clear inputs, and monitors the count value to stop at a terminal limit.

---
 rtl/counter_ctrl_if.sv | 22 ++
 rtl/counter_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl_if.sv
// Counter bus between the controller and the 16-bit event counter.
//   count_in  : current counter value fed back from the counter
//   cnt_inc   : single-cycle increment pulse to the counter
//   cnt_clr_n : active-low clear to the counter
// master = controller side, slave = counter side.
interface counter_ctrl_if;
  logic [15:0] count_in;
  logic        cnt_inc;
  logic        cnt_clr_n;

  modport master (
    input  count_in,
    output cnt_inc,
    output cnt_clr_n
  );

  modport slave (
    output count_in,
    input  cnt_inc,
    input  cnt_clr_n
  );
endinterface

// File: rtl/counter_ctrl.sv
// Sequencer for the board's 16-bit event counter.
// Debounces three push-buttons (step, run/pause, clear), runs a prescaler
// that produces an auto-increment tick while running, and arbitrates all
// increment/clear requests through a 4-state FSM. Increments stop once the
// fed-back count reaches LIMIT.
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous, active-low reset
//   btn_step  : raw button, one increment per press
//   btn_run   : raw button, toggles run/pause
//   btn_clr   : raw button, clears the counter
//   cnt       : counter bus (count_in in, cnt_inc / cnt_clr_n out)
//   state     : 00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   done      : high while state == DONE
module counter_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          TICK_DIV        = 100000000,
  parameter logic [15:0] LIMIT           = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_step,
  input  logic                  btn_run,
  input  logic                  btn_clr,
  counter_ctrl_if.master        cnt,
  output logic [1:0]            state,
  output logic                  done
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t state_q, state_nxt;

  // Button index: 0 = step, 1 = run, 2 = clear
  logic [2:0]            raw;
  logic [2:0]            sync_p0, sync_p1;
  logic [2:0][DB_W-1:0]  db_cnt;
  logic [2:0]            level_p2, level_p3;
  logic [2:0]            press_p4;

  logic                  step_p, run_p, clr_p;
  logic [PS_W-1:0]       presc;
  logic                  tick;
  logic                  inc_req;
  logic                  inc_nxt, clr_n_nxt, done_nxt;
  logic                  below_limit;

  assign raw = {btn_clr, btn_run, btn_step};

  // Stage p0/p1: two-flop synchroniser.
  // Stage p2: debounced level; the counter runs only while the sample
  //           disagrees with the accepted level, so any bounce back restarts it.
  // Stage p3/p4: delayed level and registered rising-edge press pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      db_cnt   <= '0;
      level_p2 <= '0;
      level_p3 <= '0;
      press_p4 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[i] == level_p2[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level_p2[i] <= sync_p1[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
      level_p3 <= level_p2;
      press_p4 <= level_p2 & ~level_p3;
    end
  end

  assign step_p = press_p4[0];
  assign run_p  = press_p4[1];
  assign clr_p  = press_p4[2];

  // Prescaler: held at 0 outside RUN and on the edge that leaves RUN, so
  // every RUN entry starts a full TICK_DIV period.
  assign tick = (state_q == RUN) && (presc == PS_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      presc <= '0;
    end else if (state_q != RUN || state_nxt != RUN || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign below_limit = (cnt.count_in < LIMIT);

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt.cnt_inc   <= 1'b0;
      cnt.cnt_clr_n <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      cnt.cnt_inc   <= inc_nxt;
      cnt.cnt_clr_n <= clr_n_nxt;
      done          <= done_nxt;
    end
  end

  // Next state: clear beats run beats step beats tick; losers are dropped.
  always_comb begin
    state_nxt = state_q;
    inc_req   = 1'b0;
    if (clr_p) begin
      state_nxt = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (run_p)       state_nxt = RUN;
          else if (step_p) inc_req   = 1'b1;
        end
        RUN: begin
          if (run_p)       state_nxt = PAUSE;
          else if (tick)   inc_req   = 1'b1;
        end
        PAUSE: begin
          if (run_p)       state_nxt = RUN;
          else if (step_p) inc_req   = 1'b1;
        end
        default: ;
      endcase
      // A request at or beyond the terminal count is swallowed and parks the FSM.
      if (inc_req && !below_limit) state_nxt = DONE;
    end
  end

  // Output decode
  always_comb begin
    inc_nxt   = inc_req && below_limit;
    clr_n_nxt = ~clr_p;
    done_nxt  = (state_nxt == DONE);
  end

  assign state = state_q;

endmodule
